ttl_universal_shift_reg: RTL and testbench
==========================================

Name: ttl_universal_shift_reg

Overview:
- Parametrised successor to our 4-bit universal shift register part.
- Provides WIDTH-bit storage with hold, shift, parallel load, rotate, arithmetic shift and clear modes.
- Adds a counted burst engine: one start command performs N shift/rotate steps with a busy/done handshake.
- Used in the datapath wherever the CPU needs multi-bit shifts without sequencing single steps from the control ROM.

Parameters:
- WIDTH, 8, register width in bits (>= 2).
- CNT_W, 4, width of the burst count input.

Ports:
- clock  in  1  system clock; all state updates on the rising edge.
- mr  in  1  master reset, synchronous, active-high.
- en  in  1  clock enable; when 0, no state change except reset.
- mode  in  3  operation select (encoding below).
- start  in  1  begin a counted burst using mode and count.
- count  in  CNT_W  number of burst steps.
- dsr  in  1  serial data for shift-right.
- dsl  in  1  serial data for shift-left.
- d  in  WIDTH  parallel load data.
- q  out  WIDTH  register contents.
- sol  out  1  q[WIDTH-1] (combinational).
- sor  out  1  q[0] (combinational).
- busy  out  1  burst in progress.
- done  out  1  one-cycle pulse on burst completion.

Behaviour:
- Direction convention: "right" moves data from q[0] toward q[WIDTH-1], matching the legacy part's Q0-to-QD flow.
- Mode encoding, single step:
  - 000 hold.
  - 001 shift right: q <= {q[W-2:0], dsr}.
  - 010 shift left: q <= {dsl, q[W-1:1]}.
  - 011 load: q <= d.
  - 100 rotate right: q <= {q[W-2:0], q[W-1]}.
  - 101 rotate left: q <= {q[0], q[W-1:1]}.
  - 110 arithmetic shift left: q <= {q[W-1], q[W-1:1]}.
  - 111 clear: q <= 0.
- Reset: mr=1 at an edge sets q=0, busy=0, done=0, state=IDLE and the step counter to 0.
  - Reset overrides everything, including en and a burst in progress (the burst is aborted).
- State machine: IDLE and BURST.
- IDLE, en=1, start=0:
  - Execute the mode op once at the edge.
  - Behaviour is identical to the 74x194 with a wider word.
- IDLE, en=1, start=1, mode in {001,010,100,101,110} (burst-capable):
  - Latch mode into bmode and load count into the counter; q is unchanged at this edge.
  - If count != 0: go to BURST with busy <= 1.
  - If count == 0: stay in IDLE and pulse done <= 1.
- IDLE, start=1 with mode in {000,011,111}:
  - start is ignored; the mode op executes as a single step.
- BURST, en=1:
  - Perform one bmode step and decrement the counter.
  - On the step that takes the counter from 1 to 0: same edge sets busy <= 0, done <= 1, state IDLE.
  - The final q value and done are therefore visible together.
- BURST, en=0: pause. q, counter and busy hold; no step is taken.
- In BURST, mode, d, start and count are ignored; dsr and dsl are sampled live at each step.
- count > WIDTH is legal (for example, rotate wraps fully).
- Latency: a burst of N >= 1 with en held high gives busy high for exactly N cycles after the start edge. q changes on each of those N edges.
- done is high for exactly one cycle and is 0 at all other times.
- A start on the same edge that done is asserted is not possible, because the block is in BURST at that edge. start is accepted from the following cycle.
- en=0 in IDLE: start is not accepted and q holds.

Test Plan:
- Reset: drive mr=1 with q=0xFF and busy=1 mid-burst -> next edge q=0x00, busy=0, done=0; a following load works normally.
- Load and shift (WIDTH=8):
  - mode=011, d=0xA5 -> q=0xA5.
  - Then mode=001, dsr=1 -> q=0x4B.
  - Reload 0xA5, then mode=010, dsl=0 -> q=0x52.
  - Then mode=000 for 3 cycles -> q stays 0x52.
  - sol/sor track q[7]/q[0].
- Burst rotate right: q=0x81, start=1, mode=100, count=3 -> q=0x81 at the start edge, then 0x03, 0x06, 0x0C on the next three edges.
  - busy is high for 3 cycles.
  - done pulses one cycle, coincident with q=0x0C.
- Burst arithmetic shift with pause:
  - q=0x80, mode=110, count=2 -> step 1 gives 0xC0.
  - Drop en for 2 cycles -> q=0xC0 and busy=1 held.
  - Raise en -> q=0xE0 with done pulse.
  - Changing mode/d during the burst has no effect.
- Zero count and ignored start:
  - start with count=0, mode=001 -> q unchanged, busy stays 0, done pulses once.
  - start with mode=011, d=0x3C -> q=0x3C as a plain load, no busy and no done.
- Reset mid-burst: start rotate-left with count=10 on 0x01; assert mr after 4 steps -> q=0x00, busy=0, no done pulse.
  - A subsequent burst with count=1 completes normally.

Source files
------------

// File: rtl/ttl_universal_shift_reg.sv
// ttl_universal_shift_reg
//   Parametrised universal shift register with a counted burst engine.
//   Single-step modes: hold, shift right/left, load, rotate right/left,
//   arithmetic shift left, clear. A start command with a shift/rotate mode
//   runs `count` steps back to back, reporting busy/done.
//
//   "Right" moves data from q[0] toward q[WIDTH-1] (legacy Q0->QD flow).
//
// Ports:
//   clock  in   system clock, rising edge
//   mr     in   master reset, synchronous, active-high
//   en     in   clock enable (reset still applies when low)
//   mode   in   [2:0] operation select
//   start  in   begin a counted burst
//   count  in   [CNT_W-1:0] burst step count
//   dsr    in   serial in for shift-right
//   dsl    in   serial in for shift-left
//   d      in   [WIDTH-1:0] parallel load data
//   q      out  [WIDTH-1:0] register contents
//   sol    out  q[WIDTH-1]
//   sor    out  q[0]
//   busy   out  burst in progress
//   done   out  one-cycle pulse when a burst completes
module ttl_universal_shift_reg #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 4
) (
    input  logic             clock,
    input  logic             mr,
    input  logic             en,
    input  logic [2:0]       mode,
    input  logic             start,
    input  logic [CNT_W-1:0] count,
    input  logic             dsr,
    input  logic             dsl,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q,
    output logic             sol,
    output logic             sor,
    output logic             busy,
    output logic             done
);

    localparam logic [2:0] M_HOLD = 3'b000;
    localparam logic [2:0] M_SHR  = 3'b001;
    localparam logic [2:0] M_SHL  = 3'b010;
    localparam logic [2:0] M_LOAD = 3'b011;
    localparam logic [2:0] M_ROR  = 3'b100;
    localparam logic [2:0] M_ROL  = 3'b101;
    localparam logic [2:0] M_ASL  = 3'b110;
    localparam logic [2:0] M_CLR  = 3'b111;

    typedef enum logic {IDLE, BURST} state_t;

    state_t           state;
    logic [2:0]       bmode;
    logic [CNT_W-1:0] cnt;
    logic             burst_ok;

    // One step of the register for a given operation; shared by single-step
    // and burst paths so both behave identically.
    function automatic logic [WIDTH-1:0] step_op(
        input logic [2:0]       op,
        input logic [WIDTH-1:0] cur,
        input logic             sr,
        input logic             sl,
        input logic [WIDTH-1:0] ld
    );
        logic [WIDTH-1:0] r;
        case (op)
            M_HOLD:  r = cur;
            M_SHR:   r = {cur[WIDTH-2:0], sr};
            M_SHL:   r = {sl, cur[WIDTH-1:1]};
            M_LOAD:  r = ld;
            M_ROR:   r = {cur[WIDTH-2:0], cur[WIDTH-1]};
            M_ROL:   r = {cur[0], cur[WIDTH-1:1]};
            M_ASL:   r = {cur[WIDTH-1], cur[WIDTH-1:1]};
            M_CLR:   r = '0;
            default: r = cur;
        endcase
        return r;
    endfunction

    // Only the shift/rotate modes can be repeated as a burst.
    always_comb begin
        burst_ok = 1'b0;
        case (mode)
            M_SHR, M_SHL, M_ROR, M_ROL, M_ASL: burst_ok = 1'b1;
            default:                           burst_ok = 1'b0;
        endcase
    end

    always_ff @(posedge clock) begin
        if (mr) begin
            q     <= '0;
            busy  <= 1'b0;
            done  <= 1'b0;
            state <= IDLE;
            cnt   <= '0;
            bmode <= M_HOLD;
        end else begin
            done <= 1'b0;
            if (en) begin
                case (state)
                    IDLE: begin
                        if (start && burst_ok) begin
                            // Start edge only arms the engine; q moves next edge.
                            bmode <= mode;
                            cnt   <= count;
                            if (count != '0) begin
                                state <= BURST;
                                busy  <= 1'b1;
                            end else begin
                                done <= 1'b1;
                            end
                        end else begin
                            q <= step_op(mode, q, dsr, dsl, d);
                        end
                    end
                    BURST: begin
                        q   <= step_op(bmode, q, dsr, dsl, d);
                        cnt <= cnt - 1'b1;
                        // Last step: final q and done appear together.
                        if (cnt == CNT_W'(1)) begin
                            state <= IDLE;
                            busy  <= 1'b0;
                            done  <= 1'b1;
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

    assign sol = q[WIDTH-1];
    assign sor = q[0];

endmodule

// File: tb/tb_ttl_universal_shift_reg.sv
module tb_ttl_universal_shift_reg;

    localparam int W = 8;
    localparam int CW = 4;

    logic          clock = 1'b0;
    logic          mr = 1'b1;
    logic          en = 1'b0;
    logic [2:0]    mode = 3'b000;
    logic          start = 1'b0;
    logic [CW-1:0] count = '0;
    logic          dsr = 1'b0;
    logic          dsl = 1'b0;
    logic [W-1:0]  d = '0;
    logic [W-1:0]  q;
    logic          sol, sor, busy, done;

    ttl_universal_shift_reg #(.WIDTH(W), .CNT_W(CW)) dut (
        .clock(clock), .mr(mr), .en(en), .mode(mode), .start(start),
        .count(count), .dsr(dsr), .dsl(dsl), .d(d), .q(q), .sol(sol),
        .sor(sor), .busy(busy), .done(done)
    );

    always #5 clock = ~clock;

    typedef struct packed {
        logic [W-1:0] q;
        logic         busy;
        logic         done;
    } exp_t;

    exp_t exp_q[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    // Reference model: integer arithmetic on the register value.
    int m_q = 0;
    int m_rem = 0;
    int m_op = 0;
    bit m_busy = 0;
    bit m_done = 0;

    function automatic int apply(int op, int v, int sr, int sl, int ld);
        int mask = (1 << W) - 1;
        int msb  = 1 << (W - 1);
        case (op)
            1: return ((v * 2) + sr) & mask;               // toward MSB, dsr in at bit 0
            2: return (v / 2) + sl * msb;                  // toward LSB, dsl in at MSB
            3: return ld;
            4: return ((v * 2) + (v / msb)) & mask;        // MSB wraps to bit 0
            5: return (v / 2) + (v % 2) * msb;             // bit 0 wraps to MSB
            6: return (v / 2) + (v & msb);                 // sign bit kept
            7: return 0;
            default: return v;
        endcase
    endfunction

    task automatic model_edge();
        m_done = 0;
        if (mr) begin
            m_q = 0; m_busy = 0; m_rem = 0;
        end else if (en) begin
            if (!m_busy) begin
                if (start && (int'(mode) inside {1, 2, 4, 5, 6})) begin
                    m_op = int'(mode);
                    m_rem = int'(count);
                    if (m_rem == 0) m_done = 1;
                    else m_busy = 1;
                end else begin
                    m_q = apply(int'(mode), m_q, int'(dsr), int'(dsl), int'(d));
                end
            end else begin
                m_q = apply(m_op, m_q, int'(dsr), int'(dsl), int'(d));
                m_rem--;
                if (m_rem == 0) begin
                    m_busy = 0;
                    m_done = 1;
                end
            end
        end
    endtask

    // Advance one clock: inputs already set at negedge; model updated at the
    // edge and the expectation queued for the monitor.
    task automatic tick();
        exp_t e;
        @(posedge clock);
        model_edge();
        e.q = W'(m_q);
        e.busy = m_busy;
        e.done = m_done;
        exp_q.push_back(e);
        @(negedge clock);
    endtask

    task automatic check(string name, int act, int req);
        n_cmp++;
        if (act != req) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, req);
        end
    endtask

    // Monitor: every edge produces an output sample.
    always @(posedge clock) begin
        #1;
        if (exp_q.size() > 0) begin
            exp_t e;
            e = exp_q.pop_front();
            check("sb_q", int'(q), int'(e.q));
            check("sb_busy", int'(busy), int'(e.busy));
            check("sb_done", int'(done), int'(e.done));
            check("sb_sol", int'(sol), int'(e.q[W-1]));
            check("sb_sor", int'(sor), int'(e.q[0]));
        end
    end

    task automatic setin(bit r, bit e, int md, bit st, int c, int dd);
        mr = r; en = e; mode = 3'(md); start = st; count = CW'(c); d = W'(dd);
    endtask

    initial begin
        @(negedge clock);
        setin(1, 0, 0, 0, 0, 0);
        tick();
        check("reset_q", int'(q), 0);
        check("reset_busy", int'(busy), 0);

        // Reset during a burst with q=FF.
        setin(0, 1, 3, 0, 0, 8'hFF); tick();
        setin(0, 1, 4, 1, 5, 0); tick();
        setin(0, 1, 0, 0, 0, 0); tick();
        check("pre_rst_busy", int'(busy), 1);
        check("pre_rst_q", int'(q), 8'hFF);
        setin(1, 1, 0, 0, 0, 0); tick();
        check("mid_rst_q", int'(q), 0);
        check("mid_rst_busy", int'(busy), 0);
        check("mid_rst_done", int'(done), 0);
        setin(0, 1, 3, 0, 0, 8'h5A); tick();
        check("post_rst_load", int'(q), 8'h5A);

        // Load and single shifts.
        setin(0, 1, 3, 0, 0, 8'hA5); tick();
        check("load_a5", int'(q), 8'hA5);
        dsr = 1; setin(0, 1, 1, 0, 0, 0); tick();
        check("shr_dsr1", int'(q), 8'h4B);
        setin(0, 1, 3, 0, 0, 8'hA5); tick();
        dsl = 0; setin(0, 1, 2, 0, 0, 0); tick();
        check("shl_dsl0", int'(q), 8'h52);
        setin(0, 1, 0, 0, 0, 8'hFF);
        repeat (3) tick();
        check("hold_52", int'(q), 8'h52);
        check("sor_52", int'(sor), 0);
        check("sol_52", int'(sol), 0);

        // Burst rotate right by 3.
        setin(0, 1, 3, 0, 0, 8'h81); tick();
        setin(0, 1, 4, 1, 3, 0); tick();
        check("ror_start_q", int'(q), 8'h81);
        check("ror_start_busy", int'(busy), 1);
        setin(0, 1, 0, 0, 0, 0); tick();
        check("ror_1", int'(q), 8'h03);
        tick();
        check("ror_2", int'(q), 8'h06);
        tick();
        check("ror_3", int'(q), 8'h0C);
        check("ror_done", int'(done), 1);
        check("ror_busy_end", int'(busy), 0);
        tick();
        check("ror_done_drop", int'(done), 0);

        // Arithmetic shift burst with pause; mode/d churn must not matter.
        setin(0, 1, 3, 0, 0, 8'h80); tick();
        setin(0, 1, 6, 1, 2, 0); tick();
        setin(0, 1, 3, 0, 0, 8'h11); tick();
        check("asl_1", int'(q), 8'hC0);
        setin(0, 0, 7, 1, 9, 8'h22); tick(); tick();
        check("asl_pause_q", int'(q), 8'hC0);
        check("asl_pause_busy", int'(busy), 1);
        setin(0, 1, 3, 0, 0, 8'h33); tick();
        check("asl_2", int'(q), 8'hE0);
        check("asl_done", int'(done), 1);

        // Zero-count start and ignored start on load.
        setin(0, 1, 1, 1, 0, 0); tick();
        check("zc_q", int'(q), 8'hE0);
        check("zc_done", int'(done), 1);
        check("zc_busy", int'(busy), 0);
        setin(0, 1, 3, 1, 5, 8'h3C); tick();
        check("st_load_q", int'(q), 8'h3C);
        check("st_load_busy", int'(busy), 0);
        check("st_load_done", int'(done), 0);

        // Reset mid rotate-left burst, then a 1-step burst.
        setin(0, 1, 3, 0, 0, 8'h01); tick();
        setin(0, 1, 5, 1, 10, 0); tick();
        setin(0, 1, 0, 0, 0, 0);
        repeat (4) tick();
        check("rol_4", int'(q), 8'h10);
        setin(1, 1, 0, 0, 0, 0); tick();
        check("rol_rst_q", int'(q), 0);
        check("rol_rst_busy", int'(busy), 0);
        setin(0, 1, 3, 0, 0, 8'h01); tick();
        check("rol_rst_nodone", int'(done), 0);
        setin(0, 1, 4, 1, 1, 0); tick();
        setin(0, 1, 0, 0, 0, 0); tick();
        check("one_step_q", int'(q), 8'h02);
        check("one_step_done", int'(done), 1);

        // Randomized traffic checked by the scoreboard.
        for (int i = 0; i < 400; i++) begin
            mr = ($urandom_range(0, 99) < 3);
            en = ($urandom_range(0, 99) < 80);
            mode = 3'($urandom_range(0, 7));
            start = ($urandom_range(0, 99) < 30);
            count = CW'($urandom_range(0, 15));
            dsr = 1'($urandom_range(0, 1));
            dsl = 1'($urandom_range(0, 1));
            d = W'($urandom_range(0, 255));
            tick();
        end

        setin(0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 20 && exp_q.size() != 0; i++) @(posedge clock);
        #2;
        if (exp_q.size() != 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL drain: %0d entries left, expected 0", exp_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
